// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   UART_DATA_W  : width of one received character
//   UART_ENTRY_W : width of one buffered entry (frame-error tag + data)
//   ERR_CNT_W    : width of the discarded-frame-error counter
//   rx_entry_t   : layout of one buffered entry {ferr, data}
//   sat_inc      : saturating increment for the error counter
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_ENTRY_W = UART_DATA_W + 1;
    localparam int ERR_CNT_W    = 8;

    typedef struct packed {
        logic                   ferr;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the receiver-side push signals and the host-side pop/status
// signals of the receive FIFO.
//   slave  modport : the FIFO (takes RX_* / RD_EN / CLR_OVERRUN, drives status)
//   master modport : the surrounding logic / host (drives RX_* / RD_EN / CLR_OVERRUN)
// Signals:
//   RX_DQ, RX_READY, RX_FERR  receiver byte, byte-ready level, frame error
//   RD_EN                     pop request
//   RD_DATA, RD_FERR, RD_VALID popped byte, its tag, valid strobe
//   EMPTY, FULL, ALMOST_FULL, LEVEL  occupancy status
//   OVERRUN, CLR_OVERRUN      sticky overrun flag and its clear
//   ERR_CNT                   count of discarded frame-error bytes
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [UART_DATA_W-1:0] RX_DQ;
    logic                   RX_READY;
    logic                   RX_FERR;
    logic                   RD_EN;
    logic                   CLR_OVERRUN;

    logic [UART_DATA_W-1:0] RD_DATA;
    logic                   RD_FERR;
    logic                   RD_VALID;
    logic                   EMPTY;
    logic                   FULL;
    logic                   ALMOST_FULL;
    logic [LVL_W-1:0]       LEVEL;
    logic                   OVERRUN;
    logic [ERR_CNT_W-1:0]   ERR_CNT;

    modport slave (
        input  RX_DQ, RX_READY, RX_FERR, RD_EN, CLR_OVERRUN,
        output RD_DATA, RD_FERR, RD_VALID, EMPTY, FULL, ALMOST_FULL,
               LEVEL, OVERRUN, ERR_CNT
    );

    modport master (
        output RX_DQ, RX_READY, RX_FERR, RD_EN, CLR_OVERRUN,
        input  RD_DATA, RD_FERR, RD_VALID, EMPTY, FULL, ALMOST_FULL,
               LEVEL, OVERRUN, ERR_CNT
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// ---------------------------------------------------------------------------
// rx_fifo_mem
// Simple dual-port RAM: synchronous write, registered read.
//   clk_i      clock, rising edge
//   rst_n_i    synchronous active-low reset of the read register only
//              (the array itself is never cleared)
//   wr_en_i    write strobe, wr_addr_i / wr_data_i written at the edge
//   rd_en_i    read strobe, rd_addr_i captured into rd_data_o at the edge
//   rd_data_o  registered read data, holds while rd_en_i is low
// A read and a write to the same address in one cycle return the old
// contents, which is what lets a full FIFO pop and push together.
// ---------------------------------------------------------------------------
module rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. Each rising edge of RX_READY
// pushes one {frame error, byte} entry into a circular FIFO; the host pops
// entries with a one-cycle registered read.
// Parameters:
//   DEPTH     number of entries (power of two, >= 2)
//   AF_LEVEL  ALMOST_FULL threshold on LEVEL
//   DROP_ERR  1: discard frame-error bytes and count them in ERR_CNT
//             0: store them with RD_FERR tag set
// Ports:
//   CLK    clock, rising edge
//   RST_N  synchronous active-low reset
//   bus    uart_rx_fifo_if.slave: RX_* push side, RD_* pop side, status
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int DROP_ERR = 0
) (
    input  logic          CLK,
    input  logic          RST_N,
    uart_rx_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);
    localparam logic             DROP_EN  = (DROP_ERR != 0);

    logic                 rdy_q;
    logic [PTR_W-1:0]     wp_q, wp_d;
    logic [PTR_W-1:0]     rp_q, rp_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 ovr_q, ovr_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 vld_q;

    logic                 empty, full;
    logic                 push_req, drop_ferr, push_acc, pop_acc, ovr_set;
    rx_entry_t            rd_entry;

    always_comb begin
        empty     = (level_q == '0);
        full      = (level_q == LVL_FULL);

        // One push per RX_READY rising edge, however long the level stays high.
        push_req  = bus.RX_READY & ~rdy_q;
        drop_ferr = DROP_EN & push_req & bus.RX_FERR;

        // A pop on an empty FIFO is ignored, so there is no push-through.
        pop_acc   = bus.RD_EN & ~empty;
        // When full, a same-cycle pop frees the slot the push needs.
        push_acc  = push_req & ~drop_ferr & (~full | pop_acc);
        ovr_set   = push_req & ~drop_ferr & full & ~pop_acc;

        wp_d      = push_acc ? wp_q + PTR_W'(1) : wp_q;
        rp_d      = pop_acc  ? rp_q + PTR_W'(1) : rp_q;

        level_d   = level_q;
        case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Setting wins over clearing in the same cycle.
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (bus.CLR_OVERRUN) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        err_d     = drop_ferr ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rdy_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            ovr_q   <= 1'b0;
            err_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            rdy_q   <= bus.RX_READY;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            ovr_q   <= ovr_d;
            err_q   <= err_d;
            vld_q   <= pop_acc;
        end
    end

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (UART_ENTRY_W)
    ) u_mem (
        .clk_i     (CLK),
        .rst_n_i   (RST_N),
        .wr_en_i   (push_acc),
        .wr_addr_i (wp_q),
        .wr_data_i ({bus.RX_FERR, bus.RX_DQ}),
        .rd_en_i   (pop_acc),
        .rd_addr_i (rp_q),
        .rd_data_o (rd_entry)
    );

    assign bus.RD_DATA     = rd_entry.data;
    assign bus.RD_FERR     = rd_entry.ferr;
    assign bus.RD_VALID    = vld_q;
    assign bus.EMPTY       = empty;
    assign bus.FULL        = full;
    assign bus.ALMOST_FULL = (level_q >= LVL_AF);
    assign bus.LEVEL       = level_q;
    assign bus.OVERRUN     = ovr_q;
    assign bus.ERR_CNT     = err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Two FIFOs (DROP_ERR = 0 and 1) share one directed stimulus. Each has a
// queue-based reference model and a per-cycle compare; directed checks with
// literal values pin the model down.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] rx_dq = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_ferr = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : m
        uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

        assign bus.RX_DQ       = rx_dq;
        assign bus.RX_READY    = rx_ready;
        assign bus.RX_FERR     = rx_ferr;
        assign bus.RD_EN       = rd_en;
        assign bus.CLR_OVERRUN = clr_ovr;

        uart_rx_fifo #(
            .DEPTH    (DEPTH),
            .AF_LEVEL (AF),
            .DROP_ERR (g)
        ) dut (
            .CLK   (CLK),
            .RST_N (RST_N),
            .bus   (bus)
        );

        // Reference model: FIFO as a queue of {ferr, data}.
        logic [8:0] q[$];
        bit         prev  = 0;
        bit         ovr   = 0;
        bit         vld   = 0;
        bit         live  = 0;
        int         err   = 0;
        logic [7:0] rdat  = 8'h00;
        logic       rferr = 1'b0;

        always @(posedge CLK) begin : mdl
            int         n0;
            bit         rise;
            bit         popok;
            bit         setovr;
            logic [8:0] e;
            if (!RST_N) begin
                q.delete();
                prev  = 0;
                ovr   = 0;
                err   = 0;
                vld   = 0;
                rdat  = 8'h00;
                rferr = 1'b0;
                live  = 1;
            end else begin
                n0     = q.size();
                rise   = rx_ready && !prev;
                prev   = rx_ready;
                popok  = rd_en && (n0 > 0);
                vld    = popok;
                setovr = 0;
                if (popok) begin
                    e     = q.pop_front();
                    rdat  = e[7:0];
                    rferr = e[8];
                end
                if (rise) begin
                    if (g == 1 && rx_ferr) begin
                        if (err < 255) err++;
                    end else if (n0 < DEPTH || popok) begin
                        q.push_back({rx_ferr, rx_dq});
                    end else begin
                        setovr = 1;
                    end
                end
                if (setovr) ovr = 1;
                else if (clr_ovr) ovr = 0;
            end
        end

        always @(negedge CLK) begin
            if (live) begin
                check($sformatf("d%0d.LEVEL", g),    32'(bus.LEVEL),       32'(q.size()));
                check($sformatf("d%0d.EMPTY", g),    32'(bus.EMPTY),       32'(q.size() == 0));
                check($sformatf("d%0d.FULL", g),     32'(bus.FULL),        32'(q.size() == DEPTH));
                check($sformatf("d%0d.AFULL", g),    32'(bus.ALMOST_FULL), 32'(q.size() >= AF));
                check($sformatf("d%0d.OVERRUN", g),  32'(bus.OVERRUN),     32'(ovr));
                check($sformatf("d%0d.ERR_CNT", g),  32'(bus.ERR_CNT),     32'(err));
                check($sformatf("d%0d.RD_VALID", g), 32'(bus.RD_VALID),    32'(vld));
                check($sformatf("d%0d.RD_DATA", g),  32'(bus.RD_DATA),     32'(rdat));
                check($sformatf("d%0d.RD_FERR", g),  32'(bus.RD_FERR),     32'(rferr));
            end
        end
    end

    // Returns at the negedge after the last cycle RX_READY was high.
    task automatic push_byte(input logic [7:0] d, input logic f, input int hold);
        @(negedge CLK);
        rx_dq    = d;
        rx_ferr  = f;
        rx_ready = 1'b1;
        repeat (hold) @(negedge CLK);
        rx_ready = 1'b0;
    endtask

    // One-cycle RD_EN pulse; returns where the read result is visible.
    task automatic pop_one();
        @(negedge CLK);
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check("rst.EMPTY",    32'(m[0].bus.EMPTY),    32'd1);
        check("rst.LEVEL",    32'(m[0].bus.LEVEL),    32'd0);
        check("rst.OVERRUN",  32'(m[0].bus.OVERRUN),  32'd0);
        check("rst.ERR_CNT",  32'(m[1].bus.ERR_CNT),  32'd0);
        check("rst.RD_VALID", 32'(m[0].bus.RD_VALID), 32'd0);
        RST_N = 1'b1;

        // Long RX_READY gives one push
        push_byte(8'hA5, 1'b0, 5);
        check("hold.LEVEL", 32'(m[0].bus.LEVEL), 32'd1);
        pop_one();
        check("pop.RD_VALID", 32'(m[0].bus.RD_VALID), 32'd1);
        check("pop.RD_DATA",  32'(m[0].bus.RD_DATA),  32'hA5);
        check("pop.RD_FERR",  32'(m[0].bus.RD_FERR),  32'd0);
        check("pop.EMPTY",    32'(m[0].bus.EMPTY),    32'd1);
        @(negedge CLK);
        check("pop.VALID_1cyc", 32'(m[0].bus.RD_VALID), 32'd0);
        check("pop.DATA_hold",  32'(m[0].bus.RD_DATA),  32'hA5);

        // Fill past full
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(i), 1'b0, 1);
            if (i == 10) check("fill.AF_at11", 32'(m[0].bus.ALMOST_FULL), 32'd0);
            if (i == 11) check("fill.AF_at12", 32'(m[0].bus.ALMOST_FULL), 32'd1);
            if (i == 15) begin
                check("fill.FULL",    32'(m[0].bus.FULL),    32'd1);
                check("fill.OVR_pre", 32'(m[0].bus.OVERRUN), 32'd0);
            end
        end
        check("fill.OVERRUN", 32'(m[0].bus.OVERRUN), 32'd1);
        check("fill.LEVEL",   32'(m[0].bus.LEVEL),   32'd16);

        @(negedge CLK);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            check($sformatf("drain.VALID%0d", i), 32'(m[0].bus.RD_VALID), 32'd1);
            check($sformatf("drain.DATA%0d", i),  32'(m[0].bus.RD_DATA),  32'(i));
        end
        rd_en = 1'b0;
        check("drain.EMPTY",   32'(m[0].bus.EMPTY),   32'd1);
        check("drain.OVR_sticky", 32'(m[0].bus.OVERRUN), 32'd1);
        @(negedge CLK);
        clr_ovr = 1'b1;
        @(negedge CLK);
        clr_ovr = 1'b0;
        check("clr.OVERRUN", 32'(m[0].bus.OVERRUN), 32'd0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1'b0, 1);
        check("full2.FULL", 32'(m[0].bus.FULL), 32'd1);
        @(negedge CLK);
        rd_en    = 1'b1;
        rx_dq    = 8'h55;
        rx_ferr  = 1'b0;
        rx_ready = 1'b1;
        @(negedge CLK);
        rd_en    = 1'b0;
        rx_ready = 1'b0;
        check("pp.RD_DATA", 32'(m[0].bus.RD_DATA), 32'h20);
        check("pp.LEVEL",   32'(m[0].bus.LEVEL),   32'd16);
        check("pp.OVERRUN", 32'(m[0].bus.OVERRUN), 32'd0);
        @(negedge CLK);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (i == 0)  check("pp.first", 32'(m[0].bus.RD_DATA), 32'h21);
            if (i == 15) check("pp.last",  32'(m[0].bus.RD_DATA), 32'h55);
        end
        rd_en = 1'b0;

        // Frame-error byte: stored tagged vs. discarded and counted
        push_byte(8'h3C, 1'b1, 1);
        check("ferr.d1_LEVEL", 32'(m[1].bus.LEVEL),   32'd0);
        check("ferr.d1_ERR",   32'(m[1].bus.ERR_CNT), 32'd1);
        pop_one();
        check("ferr.d0_DATA",  32'(m[0].bus.RD_DATA),  32'h3C);
        check("ferr.d0_FERR",  32'(m[0].bus.RD_FERR),  32'd1);
        check("ferr.d1_VALID", 32'(m[1].bus.RD_VALID), 32'd0);
        check("ferr.d0_ERR",   32'(m[0].bus.ERR_CNT),  32'd0);

        for (int i = 0; i < 300; i++) push_byte(8'(i), 1'b1, 1);
        check("sat.d1_ERR",   32'(m[1].bus.ERR_CNT), 32'd255);
        check("sat.d1_LEVEL", 32'(m[1].bus.LEVEL),   32'd0);
        check("sat.d0_FULL",  32'(m[0].bus.FULL),    32'd1);

        // Reset mid-operation with RD_EN high
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 7; i++) push_byte(8'(8'h70 + i), 1'b0, 1);
        check("mid.LEVEL7", 32'(m[0].bus.LEVEL), 32'd7);
        @(negedge CLK);
        rd_en = 1'b1;
        RST_N = 1'b0;
        @(negedge CLK);
        check("mid.LEVEL",    32'(m[0].bus.LEVEL),    32'd0);
        check("mid.EMPTY",    32'(m[0].bus.EMPTY),    32'd1);
        check("mid.RD_VALID", 32'(m[0].bus.RD_VALID), 32'd0);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("emptyrd.VALID%0d", i), 32'(m[0].bus.RD_VALID), 32'd0);
        end
        rd_en = 1'b0;

        // RX_READY already high when reset releases
        @(negedge CLK);
        RST_N    = 1'b0;
        rx_dq    = 8'h99;
        rx_ferr  = 1'b0;
        rx_ready = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("rel.LEVEL", 32'(m[0].bus.LEVEL), 32'd1);
        rx_ready = 1'b0;
        pop_one();
        check("rel.RD_DATA", 32'(m[0].bus.RD_DATA), 32'h99);
        repeat (2) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
